// File: rtl/vpifo_task_dispatch.sv
// Multi-port task queue with per-RPU round-robin dispatch, pop spacing,
// and combined push+pop tasks for the SRAM vPIFO ring.
module vpifo_task_dispatch #(
   parameter int PTW       = 16,
   parameter int MTW       = 0,
   parameter int LEVEL     = 4,
   parameter int TREE_NUM  = 16,
   parameter int PORT_NUM  = 4,
   parameter int FIFO_SIZE = 8,
   parameter int POP_GAP   = 2,
   localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
   localparam int FIFO_WIDTH    = $clog2(FIFO_SIZE),
   localparam int DW            = MTW + PTW
) (
   input  logic                                     i_clk,
   input  logic                                     i_arst_n,
   input  logic [PORT_NUM-1:0]                      i_push,
   input  logic [PORT_NUM-1:0]                      i_pop,
   input  logic [PORT_NUM-1:0][TREE_NUM_BITS-1:0]   i_tree_id,
   input  logic [PORT_NUM-1:0][DW-1:0]              i_push_data,
   output logic [PORT_NUM-1:0]                      o_fifo_full,
   output logic [PORT_NUM-1:0][FIFO_WIDTH:0]        o_fifo_count,
   output logic [PORT_NUM-1:0]                      o_drop,
   input  logic [LEVEL-1:0]                         i_rpu_ready,
   output logic [LEVEL-1:0]                         o_rpu_push,
   output logic [LEVEL-1:0]                         o_rpu_pop,
   output logic [LEVEL-1:0][TREE_NUM_BITS-1:0]      o_rpu_tree_id,
   output logic [LEVEL-1:0][DW-1:0]                 o_rpu_push_data
);

   localparam int LB = (LEVEL > 1) ? $clog2(LEVEL) : 1;
   localparam int PW = $clog2(PORT_NUM);
   localparam int CW = (POP_GAP > 0) ? $clog2(POP_GAP + 1) : 1;
   localparam logic [FIFO_WIDTH:0] FULL = (FIFO_WIDTH + 1)'(FIFO_SIZE);

   typedef struct packed {
      logic [1:0]               op;
      logic [TREE_NUM_BITS-1:0] tree;
      logic [DW-1:0]            data;
   } entry_t;

   entry_t                mem [PORT_NUM][FIFO_SIZE];
   logic [FIFO_WIDTH-1:0] wr_ptr [PORT_NUM];
   logic [FIFO_WIDTH-1:0] rd_ptr [PORT_NUM];
   logic [FIFO_WIDTH:0]   cnt [PORT_NUM];
   logic [PW-1:0]         rr [LEVEL];
   logic [CW-1:0]         cd [LEVEL];

   entry_t                head [PORT_NUM];
   entry_t                wdata [PORT_NUM];
   logic [PORT_NUM-1:0]   enq, deq, drop;
   logic [LEVEL-1:0]      gv;
   logic [PW-1:0]         gsel [LEVEL];
   int                    idx;

   always_comb begin
      enq = '0;
      drop = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
         head[p] = mem[p][rd_ptr[p]];
         wdata[p].op = {i_pop[p], i_push[p]};
         wdata[p].tree = i_tree_id[p];
         wdata[p].data = i_push[p] ? i_push_data[p] : '0;
         enq[p] = (i_push[p] | i_pop[p]) && (cnt[p] != FULL);
         drop[p] = (i_push[p] | i_pop[p]) && (cnt[p] == FULL);
      end
   end

   // Scan from rr[r] upward; a pop-carrying head under cooldown only
   // removes its own port from the race.
   always_comb begin
      deq = '0;
      gv = '0;
      idx = 0;
      for (int r = 0; r < LEVEL; r++) begin
         gsel[r] = '0;
         for (int k = 0; k < PORT_NUM; k++) begin
            idx = (int'(rr[r]) + k) % PORT_NUM;
            if (!gv[r] && cnt[idx] != '0 && i_rpu_ready[r]
                && int'(head[idx].tree[LB-1:0]) == r
                && !(head[idx].op[1] && cd[r] != '0)) begin
               gv[r] = 1'b1;
               gsel[r] = PW'(idx);
               deq[idx] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      for (int p = 0; p < PORT_NUM; p++)
         if (enq[p]) mem[p][wr_ptr[p]] <= wdata[p];
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         for (int p = 0; p < PORT_NUM; p++) begin
            wr_ptr[p] <= '0;
            rd_ptr[p] <= '0;
            cnt[p] <= '0;
         end
         for (int r = 0; r < LEVEL; r++) begin
            rr[r] <= '0;
            cd[r] <= '0;
            o_rpu_tree_id[r] <= '0;
            o_rpu_push_data[r] <= '1;
         end
         o_drop <= '0;
         o_rpu_push <= '0;
         o_rpu_pop <= '0;
      end else begin
         for (int p = 0; p < PORT_NUM; p++) begin
            if (enq[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
            if (deq[p]) rd_ptr[p] <= rd_ptr[p] + 1'b1;
            cnt[p] <= cnt[p] + (FIFO_WIDTH + 1)'(enq[p])
                             - (FIFO_WIDTH + 1)'(deq[p]);
         end
         o_drop <= drop;
         for (int r = 0; r < LEVEL; r++) begin
            o_rpu_push[r] <= gv[r] & head[gsel[r]].op[0];
            o_rpu_pop[r] <= gv[r] & head[gsel[r]].op[1];
            o_rpu_tree_id[r] <= gv[r] ? head[gsel[r]].tree : '0;
            o_rpu_push_data[r] <= (gv[r] && head[gsel[r]].op[0])
                                  ? head[gsel[r]].data : '1;
            if (gv[r])
               rr[r] <= (int'(gsel[r]) == PORT_NUM - 1) ? '0 : gsel[r] + 1'b1;
            if (gv[r] && head[gsel[r]].op[1])
               cd[r] <= CW'(POP_GAP);
            else if (cd[r] != '0)
               cd[r] <= cd[r] - 1'b1;
         end
      end
   end

   always_comb begin
      for (int p = 0; p < PORT_NUM; p++) begin
         o_fifo_count[p] = cnt[p];
         o_fifo_full[p] = (cnt[p] == FULL);
      end
   end

endmodule

// File: tb/tb_vpifo_task_dispatch.sv
// Directed and randomized checks of vpifo_task_dispatch against a
// queue-based model of the dispatch rules.
module tb_vpifo_task_dispatch;

   localparam int P = 4;
   localparam int L = 4;
   localparam int FS = 8;
   localparam int GAP = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [P-1:0] push, pop;
   logic [P-1:0][3:0] tree;
   logic [P-1:0][15:0] data;
   logic [L-1:0] rdy;
   logic [P-1:0] fifo_full;
   logic [P-1:0][3:0] fifo_count;
   logic [P-1:0] drop;
   logic [L-1:0] rpu_push, rpu_pop;
   logic [L-1:0][3:0] rpu_tree;
   logic [L-1:0][15:0] rpu_data;

   always #5 clk = ~clk;

   vpifo_task_dispatch dut (
      .i_clk(clk),
      .i_arst_n(rst_n),
      .i_push(push),
      .i_pop(pop),
      .i_tree_id(tree),
      .i_push_data(data),
      .o_fifo_full(fifo_full),
      .o_fifo_count(fifo_count),
      .o_drop(drop),
      .i_rpu_ready(rdy),
      .o_rpu_push(rpu_push),
      .o_rpu_pop(rpu_pop),
      .o_rpu_tree_id(rpu_tree),
      .o_rpu_push_data(rpu_data)
   );

   typedef struct {
      bit [1:0] op;
      bit [3:0] tree;
      bit [15:0] data;
   } ent_t;

   ent_t q[P][$];
   int rr[L];
   int cd[L];
   bit e_push[L], e_pop[L];
   bit [3:0] e_tree[L];
   bit [15:0] e_data[L];
   bit e_drop[P];
   int checks = 0;
   int errors = 0;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < P; p++) begin
         q[p].delete();
         e_drop[p] = 0;
      end
      for (int r = 0; r < L; r++) begin
         rr[r] = 0;
         cd[r] = 0;
         e_push[r] = 0;
         e_pop[r] = 0;
         e_tree[r] = 0;
         e_data[r] = 16'hFFFF;
      end
   endtask

   // One clock of the dispatch rules applied to the model queues.
   task automatic model_cycle();
      int g[L];
      int sz[P];
      ent_t e;
      for (int p = 0; p < P; p++) sz[p] = q[p].size();
      for (int r = 0; r < L; r++) begin
         g[r] = -1;
         if (rdy[r])
            for (int k = 0; k < P; k++) begin
               int pp;
               pp = (rr[r] + k) % P;
               if (g[r] < 0 && q[pp].size() > 0 && q[pp][0].tree % L == r
                   && !(q[pp][0].op[1] && cd[r] != 0))
                  g[r] = pp;
            end
      end
      for (int r = 0; r < L; r++) begin
         e_push[r] = 0;
         e_pop[r] = 0;
         e_tree[r] = 0;
         e_data[r] = 16'hFFFF;
         if (g[r] >= 0) begin
            e = q[g[r]].pop_front();
            e_push[r] = e.op[0];
            e_pop[r] = e.op[1];
            e_tree[r] = e.tree;
            if (e.op[0]) e_data[r] = e.data;
            rr[r] = (g[r] + 1) % P;
         end
         if (g[r] >= 0 && e.op[1]) cd[r] = GAP;
         else if (cd[r] > 0) cd[r]--;
      end
      for (int p = 0; p < P; p++) begin
         e_drop[p] = 0;
         if (push[p] || pop[p]) begin
            if (sz[p] == FS) e_drop[p] = 1;
            else begin
               e.op = {pop[p], push[p]};
               e.tree = tree[p];
               e.data = push[p] ? data[p] : 16'h0;
               q[p].push_back(e);
            end
         end
      end
   endtask

   task automatic step();
      model_cycle();
      @(posedge clk);
      #1;
      for (int r = 0; r < L; r++) begin
         check($sformatf("push%0d", r), 32'(rpu_push[r]), 32'(e_push[r]));
         check($sformatf("pop%0d", r), 32'(rpu_pop[r]), 32'(e_pop[r]));
         check($sformatf("data%0d", r), 32'(rpu_data[r]), 32'(e_data[r]));
         if (e_push[r] || e_pop[r])
            check($sformatf("tree%0d", r), 32'(rpu_tree[r]), 32'(e_tree[r]));
      end
      for (int p = 0; p < P; p++) begin
         check($sformatf("drop%0d", p), 32'(drop[p]), 32'(e_drop[p]));
         check($sformatf("count%0d", p), 32'(fifo_count[p]), 32'(q[p].size()));
         check($sformatf("full%0d", p), 32'(fifo_full[p]),
               32'(q[p].size() == FS));
      end
   endtask

   task automatic clear();
      push = '0;
      pop = '0;
      tree = '0;
      data = '0;
   endtask

   task automatic req(int p, bit pu, bit po, int t, int d);
      push[p] = pu;
      pop[p] = po;
      tree[p] = 4'(t);
      data[p] = 16'(d);
   endtask

   // Reset is asserted between edges so its asynchronous effect is visible.
   task automatic do_reset();
      clear();
      rst_n = 1'b0;
      #1;
      check("rst_push", 32'(rpu_push), 32'h0);
      check("rst_pop", 32'(rpu_pop), 32'h0);
      check("rst_drop", 32'(drop), 32'h0);
      check("rst_count", 32'(fifo_count), 32'h0);
      check("rst_full", 32'(fifo_full), 32'h0);
      check("rst_data", 32'(rpu_data[0]), 32'hFFFF);
      check("rst_tree", 32'(rpu_tree), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      clear();
      rdy = '1;
      #2;
      do_reset();

      // single push, 2-cycle latency
      req(0, 1, 0, 5, 'h1234);
      step();
      clear();
      step();
      check("s1_push", 32'(rpu_push), 32'h2);
      check("s1_pop", 32'(rpu_pop), 32'h0);
      check("s1_tree", 32'(rpu_tree[1]), 32'h5);
      check("s1_data", 32'(rpu_data[1]), 32'h1234);
      check("s1_idle", 32'(rpu_data[0]), 32'hFFFF);

      // round robin on RPU2, two bursts
      do_reset();
      for (int p = 0; p < P; p++) req(p, 1, 0, 2, p);
      step();
      clear();
      for (int i = 0; i < P; i++) begin
         step();
         check("s2_rr", 32'(rpu_data[2]), 32'(i));
      end
      for (int p = P - 1; p >= 0; p--) req(p, 1, 0, 2, 16 + p);
      step();
      clear();
      for (int i = 0; i < P; i++) begin
         step();
         check("s2_wrap", 32'(rpu_data[2]), 32'(16 + i));
      end

      // pop spacing on RPU3
      do_reset();
      req(0, 0, 1, 3, 0);
      req(1, 1, 0, 7, 'h77);
      step();
      clear();
      req(0, 0, 1, 3, 0);
      step();
      clear();
      check("s3_pop_t2", 32'(rpu_pop[3]), 32'h1);
      step();
      check("s3_push_t3", 32'({rpu_push[3], rpu_pop[3]}), 32'h2);
      check("s3_data_t3", 32'(rpu_data[3]), 32'h77);
      step();
      check("s3_gap_t4", 32'(rpu_pop[3]), 32'h0);
      step();
      check("s3_pop_t5", 32'(rpu_pop[3]), 32'h1);

      // push+pop replace
      do_reset();
      req(2, 1, 1, 0, 'hABCD);
      step();
      clear();
      step();
      check("s4_both", 32'({rpu_push[0], rpu_pop[0]}), 32'h3);
      check("s4_data", 32'(rpu_data[0]), 32'hABCD);
      req(2, 0, 1, 0, 0);
      step();
      clear();
      step();
      check("s4_cool", 32'(rpu_pop[0]), 32'h0);
      step();
      check("s4_pop", 32'(rpu_pop[0]), 32'h1);

      // overflow and drop
      do_reset();
      rdy = '0;
      for (int i = 0; i < FS + 1; i++) begin
         req(1, 1, 0, 1, 'h100 + i);
         step();
         if (i == FS - 1) check("s5_full", 32'(fifo_full[1]), 32'h1);
      end
      check("s5_drop", 32'(drop[1]), 32'h1);
      check("s5_count", 32'(fifo_count[1]), 32'h8);
      clear();
      rdy = '1;
      for (int i = 0; i < FS; i++) begin
         step();
         check("s5_order", 32'(rpu_data[1]), 32'('h100 + i));
      end

      // reset mid-operation
      do_reset();
      req(0, 0, 1, 0, 0);
      step();
      clear();
      rdy = 4'b1101;
      for (int p = 1; p < P; p++) req(p, 1, 0, 1, p);
      step();
      step();
      clear();
      do_reset();
      rdy = '1;
      req(0, 0, 1, 0, 0);
      step();
      clear();
      step();
      check("s6_pop", 32'(rpu_pop[0]), 32'h1);

      // randomized traffic
      do_reset();
      for (int n = 0; n < 500; n++) begin
         for (int p = 0; p < P; p++) begin
            push[p] = ($urandom_range(0, 9) < 3);
            pop[p] = ($urandom_range(0, 9) < 2);
            tree[p] = 4'($urandom_range(0, 15));
            data[p] = 16'($urandom);
         end
         for (int r = 0; r < L; r++) rdy[r] = ($urandom_range(0, 9) < 7);
         step();
      end
      clear();
      rdy = '1;
      repeat (40) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vpifo_task_dispatch.md
Name: vpifo_task_dispatch

Overview:
- Multi-port task queue and dispatcher feeding the per-level RPUs of the SRAM vPIFO tree.
- Generalises the per-level TaskFIFO plus distribute pair in four ways:
  - the ingress port count is independent of LEVEL;
  - per-RPU round-robin arbitration;
  - per-RPU pop-spacing enforcement;
  - a combined push+pop (replace) task, where the previous generation discarded both.
- Sits between the host-facing ports and the rpu_push/rpu_pop/rpu_treeId/rpu_push_data inputs of the PIFO ring.

Parameters:
- PTW, 16, payload width
- MTW, 0, metadata width
- LEVEL, 4, number of RPUs/levels; power of 2
- TREE_NUM, 16, number of virtual trees; TREE_NUM_BITS = $clog2(TREE_NUM) >= $clog2(LEVEL)
- PORT_NUM, 4, ingress ports; >= 2
- FIFO_SIZE, 8, entries per port FIFO; power of 2; FIFO_WIDTH = $clog2(FIFO_SIZE)
- POP_GAP, 2, minimum idle cycles between two pop-carrying tasks to the same RPU; 0 disables

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  asynchronous active-low reset
- i_push  in  [PORT_NUM]  push request per port
- i_pop  in  [PORT_NUM]  pop request per port
- i_tree_id  in  [TREE_NUM_BITS] x PORT_NUM  target tree
- i_push_data  in  [MTW+PTW] x PORT_NUM  push payload
- o_fifo_full  out  [PORT_NUM]  port FIFO count == FIFO_SIZE
- o_fifo_count  out  [FIFO_WIDTH+1] x PORT_NUM  occupancy
- o_drop  out  [PORT_NUM]  request dropped (registered pulse)
- i_rpu_ready  in  [LEVEL]  RPU r may accept a task this cycle
- o_rpu_push  out  [LEVEL]  push pulse to RPU r
- o_rpu_pop  out  [LEVEL]  pop pulse to RPU r
- o_rpu_tree_id  out  [TREE_NUM_BITS] x LEVEL  tree of issued task
- o_rpu_push_data  out  [MTW+PTW] x LEVEL  payload; all-ones when o_rpu_push=0

Behaviour:
- Clock and reset: one clock domain, i_clk. Asynchronous active-low reset i_arst_n clears all state immediately, including mid-operation:
  - all FIFOs empty; round-robin pointers = 0; cooldown counters = 0;
  - o_rpu_push/o_rpu_pop/o_drop = 0; o_rpu_tree_id = 0; o_rpu_push_data = all-ones;
  - o_fifo_count = 0; o_fifo_full = 0.
- Enqueue: a request on port p exists when i_push|i_pop. The entry stored is {op[1:0], tree_id, data}:
  - op 01 = push;
  - op 10 = pop, data stored as 0;
  - op 11 = push+pop.
- Enqueue decision uses count at cycle start. If count == FIFO_SIZE the request is dropped and o_drop[p] = 1 for the next cycle. A same-cycle dequeue does not rescue a drop.
- Head eligibility: target RPU r = tree_id[$clog2(LEVEL)-1:0]. The head of port p is eligible for r when all of:
  - the FIFO is non-empty;
  - i_rpu_ready[r] = 1;
  - the head is not pop-carrying while cooldown[r] != 0.
- Arbitration, per RPU:
  - Among eligible ports, grant the first index found at or after rr[r], scanning upward modulo PORT_NUM.
  - On grant, rr[r] <= grant+1 mod PORT_NUM; with no grant, rr[r] holds.
  - Each port can be granted by at most one RPU per cycle (only its head targets one RPU).
  - A pop-blocked head blocks its own port only; other ports may still win r.
- Issue: a grant in cycle t dequeues the head (count -1 at edge t+1) and drives the registered outputs in cycle t+1 as one-cycle pulses:
  - op 01: push=1, pop=0;
  - op 10: push=0, pop=1;
  - op 11: push=1 and pop=1 together.
  - o_rpu_tree_id holds the full tree id.
- Cooldown: issuing a pop-carrying task to r loads cooldown[r] = POP_GAP; otherwise the counter decrements while non-zero. With POP_GAP = 2, pops to one RPU appear at t+1 and no earlier than t+4.
- Latency: minimum request-to-output is 2 cycles (enqueue edge, then grant, then registered output).
- Simultaneous enqueue and dequeue on one port: count unchanged. Read/write pointers wrap modulo FIFO_SIZE.
- Ordering: per-port FIFO order is preserved, including across different RPUs.
- o_fifo_full and o_fifo_count are registered state and reflect counts after each edge.

Test Plan:
- Reset, then port0 push tree 5 (LEVEL 4) data 0x1234 at t=0 → o_rpu_push[1]=1, tree_id 5, data 0x1234 at t=2; all other outputs idle, data all-ones.
- Ports 0..3 push tree 2 simultaneously, i_rpu_ready all 1 → RPU2 issues ports 0,1,2,3 on consecutive cycles; a second burst starts at port 0 (rr wrapped).
- Port0 issues pops tree 3 back-to-back, POP_GAP=2 → o_rpu_pop[3] at t=2 and t=5. Port1 push tree 7 queued meanwhile issues at t=3.
- Port2 push+pop tree 0 data 0xABCD → o_rpu_push[0] and o_rpu_pop[0] both 1 in the same cycle, data 0xABCD; cooldown[0] loaded.
- i_rpu_ready=0 while port1 enqueues 9 pushes, FIFO_SIZE 8 → o_fifo_full=1 after 8, 9th gives o_drop[1]=1 one cycle later, count stays 8. Raise ready → 8 issues in order.
- Assert i_arst_n=0 with 3 entries queued and a cooldown active → counts 0, outputs idle immediately; first post-reset pop issues without gap.
